// File: rtl/or_line_arbiter_if.sv
// ---------------------------------------------------------------------------
// or_line_arbiter_if
// Bundles the signals between the requesters and the shared-line arbiter.
//   en      : arbitration enable (requester side -> arbiter)
//   req     : request vector, bit i = requester i
//   din     : data bit per requester
//   gnt     : one-hot grant or all zero
//   out     : shared line, OR of din gated by gnt
//   owner   : index of the current/last granted requester
//   busy    : a grant is active
//   timeout : one-cycle pulse on forced release
// Modports: master = requester side, slave = arbiter.
// ---------------------------------------------------------------------------
interface or_line_arbiter_if #(
    parameter int N = 4
);
    logic                   en;
    logic [N-1:0]           req;
    logic [N-1:0]           din;
    logic [N-1:0]           gnt;
    logic                   out;
    logic [$clog2(N)-1:0]   owner;
    logic                   busy;
    logic                   timeout;

    modport master (
        output en, req, din,
        input  gnt, out, owner, busy, timeout
    );

    modport slave (
        input  en, req, din,
        output gnt, out, owner, busy, timeout
    );
endinterface

// File: rtl/or_line_arbiter.sv
// ---------------------------------------------------------------------------
// or_line_arbiter
// Round-robin arbiter giving exclusive ownership of one shared single-bit
// line to one of N requesters, with an optional bounded hold time.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous, active-low reset
//   bus   : or_line_arbiter_if.slave (en, req, din in; gnt, out, owner,
//           busy, timeout out)
// Parameters:
//   N        : number of requesters (>= 2)
//   MAX_HOLD : max consecutive grant cycles before forced release, 0 = none
// ---------------------------------------------------------------------------
module or_line_arbiter #(
    parameter int N        = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    or_line_arbiter_if.slave   bus
);
    localparam int IDX_W = $clog2(N);
    localparam int CNT_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    // Counter value seen at the edge that ends the MAX_HOLD-th grant cycle
    // (the counter starts at 0 during the first grant cycle).
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t             state;
    logic [IDX_W-1:0]   ptr;
    logic [CNT_W-1:0]   cnt;
    logic [N-1:0]       gnt_q;
    logic [IDX_W-1:0]   owner_q;
    logic               busy_q;
    logic               timeout_q;
    logic [IDX_W-1:0]   pick;

    // First requester at or above the pointer, wrapping modulo N. The loop
    // walks downward in priority so the nearest match is written last.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [N-1:0] r,
                                                 input logic [IDX_W-1:0] p);
        logic [IDX_W-1:0] sel;
        int               idx;
        sel = p;
        for (int k = N - 1; k >= 0; k--) begin
            idx = (int'(p) + k) % N;
            if (r[idx]) sel = IDX_W'(idx);
        end
        return sel;
    endfunction

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
        return IDX_W'((int'(i) + 1) % N);
    endfunction

    assign pick = rr_pick(bus.req, ptr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= '0;
            cnt       <= '0;
            gnt_q     <= '0;
            owner_q   <= '0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            case (state)
                IDLE: begin
                    // Returning through IDLE guarantees a gnt=0 cycle
                    // between any two grants.
                    if (bus.en && (|bus.req)) begin
                        gnt_q   <= N'(1) << pick;
                        owner_q <= pick;
                        busy_q  <= 1'b1;
                        cnt     <= '0;
                        state   <= GRANT;
                    end
                end
                GRANT: begin
                    // Normal release wins over a coincident timeout.
                    if (!bus.req[owner_q]) begin
                        gnt_q  <= '0;
                        busy_q <= 1'b0;
                        ptr    <= next_idx(owner_q);
                        state  <= IDLE;
                    end else if ((MAX_HOLD > 0) && (cnt == HOLD_LAST)) begin
                        gnt_q     <= '0;
                        busy_q    <= 1'b0;
                        ptr       <= next_idx(owner_q);
                        timeout_q <= 1'b1;
                        state     <= IDLE;
                    end else if (cnt != '1) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.gnt     = gnt_q;
    assign bus.owner   = owner_q;
    assign bus.busy    = busy_q;
    assign bus.timeout = timeout_q;
    // Unregistered so the line tracks the owner's data within the cycle.
    assign bus.out     = |(bus.din & gnt_q);
endmodule

// File: doc/or_line_arbiter.md
Name: or_line_arbiter

Overview:
- Round-robin arbiter that shares one single-bit output line between N requesters.
- Each requester drives a data bit. The line carries the OR of each data bit gated by its grant, so only the granted requester's bit reaches it.
- Sits in front of the gate-level OR-combining logic. It makes sure exactly one source owns the combined line at a time, with a bounded hold time.

Parameters:
- N, 4, number of requesters (≥2).
- MAX_HOLD, 8, maximum consecutive grant cycles before forced release. 0 disables the timeout.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  reset, asynchronous assert, active-low
- en  input  1  arbitration enable. Low blocks new grants only.
- req  input  N  request vector, bit i = requester i
- din  input  N  data bit per requester
- gnt  output  N  one-hot grant (or all zero), registered
- out  output  1  shared line
- owner  output  $clog2(N)  index of current/last granted requester, registered
- busy  output  1  high while a grant is active, registered
- timeout  output  1  one-cycle pulse on forced release, registered

Behaviour:
- Reset (rst_n low, async, no clock needed):
  - gnt=0, busy=0, owner=0, timeout=0, out=0.
  - Round-robin pointer=0, hold counter=0, state IDLE.
- out is combinational: OR over i of (din[i] AND gnt[i]). It is 0 whenever gnt=0. It has no register stage, so it follows din of the owner in the same cycle.
- States: IDLE, GRANT.
- IDLE:
  - At each edge with en=1 and req≠0, select the first i with req[i]=1, searching from the pointer upward modulo N.
  - Next cycle: gnt=onehot(i), owner=i, busy=1, counter=0, state GRANT.
  - Latency: req sampled high at edge k gives gnt high from edge k onward (visible in cycle k+1).
  - en=0 or req=0: stay IDLE, outputs unchanged.
- GRANT:
  - Counter increments each cycle, saturating width ≥ $clog2(MAX_HOLD+1).
  - Normal release: req[owner] sampled low at an edge. Then gnt=0, busy=0, pointer=(owner+1) mod N, state IDLE. timeout stays 0.
  - Forced release (MAX_HOLD>0): req[owner] still high at the edge ending the MAX_HOLD-th grant cycle. Then gnt=0, busy=0, pointer=(owner+1) mod N, timeout=1 for exactly the next cycle, state IDLE.
  - Result: gnt[owner] is high exactly MAX_HOLD cycles under forced release.
  - Release and timeout condition on the same edge: treated as normal release, timeout=0.
- Gap: at least one cycle with gnt=0 between any two grants, including back-to-back grants to the same requester. Never two bits of gnt high.
- en:
  - Affects only IDLE.
  - Deasserting en during GRANT does not end the grant.
  - Release still returns to IDLE.
- Non-owner req changes during GRANT are ignored. They are evaluated at the next IDLE arbitration.
- A preempted requester that is the sole requester is re-granted after the one-cycle gap.
- owner holds its last value while IDLE.
- Pointer wraps N-1→0.
- Async reset mid-grant: all outputs clear immediately, and the pointer returns to 0.

Test Plan:
1. Reset: assert rst_n=0 mid-simulation without clock edges → gnt=0000, out=0, busy=0, owner=0, timeout=0 immediately.
2. Single request, data path:
   - req=0100 from reset with en=1 → after one edge gnt=0100, owner=2, busy=1.
   - din=1011 → out=0. Toggle din[2] → out follows in the same cycle.
   - Drop req[2] → gnt=0 after the next edge.
3. Round-robin order:
   - req=1111 held; each owner drops its req for one cycle after 2 grant cycles, then re-raises it.
   - Required grant sequence: 0001, 0010, 0100, 1000, 0001.
   - Exactly one gnt=0 cycle between consecutive grants; never two bits high.
4. Timeout, MAX_HOLD=8:
   - req[1] and req[3] held high.
   - gnt=0010 for exactly 8 cycles, then gnt=0 with timeout=1 for one cycle, then gnt=1000.
   - With only req[1] held: gnt=0010 regrants after the 1-cycle gap.
5. Enable gating:
   - en=0 with req=0001 → gnt stays 0 for 5 cycles.
   - Raise en → gnt=0001 after the next edge.
   - Drop en during the grant → grant persists until req[0] falls.
6. Simultaneous edge cases:
   - MAX_HOLD=4; req[0] falls on the same edge that would time out → release with timeout=0.
   - Pointer wrap: grant to 3, then req=1001 → next grant 0001.
